// File: rtl/control_input_frontend_pkg.sv
// Shared constants for the control input front-end: LFSR taps, piece fallback, default timing.
package control_input_frontend_pkg;

    localparam int unsigned LFSR_W     = 8;
    localparam int unsigned DEBOUNCE_W = 20;
    localparam int unsigned REPEAT_W   = 24;

    localparam logic [LFSR_W-1:0] LFSR_TAPS          = 8'hB8;
    localparam logic [LFSR_W-1:0] LFSR_SEED_FALLBACK = 8'h01;
    localparam logic [2:0]        PIECE_FALLBACK     = 3'b001;

    localparam logic [DEBOUNCE_W-1:0] DEF_DEBOUNCE      = 20'd250000;
    localparam logic [LFSR_W-1:0]     DEF_SEED          = 8'h01;
    localparam logic [REPEAT_W-1:0]   DEF_REPEAT_DELAY  = 24'd12500000;
    localparam logic [REPEAT_W-1:0]   DEF_REPEAT_PERIOD = 24'd5000000;

    // Fibonacci step for x^8+x^6+x^5+x^4+1
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/control_input_frontend_btn_conditioner.sv
// One push-button channel: 2-flop synchronizer, debounce, press pulse.
// Optional auto-repeat when BTN_AUTOREPEAT_EN is defined.
module btn_conditioner
    import control_input_frontend_pkg::*;
#(
    parameter logic [DEBOUNCE_W-1:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE
`ifdef BTN_AUTOREPEAT_EN
    , parameter logic [REPEAT_W-1:0] REPEAT_DELAY  = DEF_REPEAT_DELAY
    , parameter logic [REPEAT_W-1:0] REPEAT_PERIOD = DEF_REPEAT_PERIOD
    , parameter bit                  REPEAT_ALLOW  = 1'b1
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    // A zero debounce setting behaves as one cycle
    localparam logic [DEBOUNCE_W-1:0] DEB_LAST =
        (DEBOUNCE_CYCLES == {DEBOUNCE_W{1'b0}}) ? {DEBOUNCE_W{1'b0}}
                                                : DEBOUNCE_CYCLES - DEBOUNCE_W'(1);

    logic                  s1;
    logic                  s2;
    logic                  level;
    logic [DEBOUNCE_W-1:0] cnt;
    logic                  accept;
    logic                  press;

    assign accept = (s2 != level) && (cnt == DEB_LAST);
    assign press  = accept && s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            if ((s2 == level) || accept) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DEBOUNCE_W'(1);
            end
            if (accept) begin
                level <= s2;
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [REPEAT_W-1:0] DELAY_LAST =
        (REPEAT_DELAY == {REPEAT_W{1'b0}}) ? {REPEAT_W{1'b0}} : REPEAT_DELAY - REPEAT_W'(1);
    localparam logic [REPEAT_W-1:0] PERIOD_LAST =
        (REPEAT_PERIOD == {REPEAT_W{1'b0}}) ? {REPEAT_W{1'b0}} : REPEAT_PERIOD - REPEAT_W'(1);

    logic [REPEAT_W-1:0] rpt_cnt;
    logic                rpt_first;
    logic                rpt_fire;

    assign rpt_fire = REPEAT_ALLOW && level &&
                      (rpt_first ? (rpt_cnt == DELAY_LAST) : (rpt_cnt == PERIOD_LAST));

    // Age of the current hold; first interval uses the delay, later ones the period
    always_ff @(posedge clk) begin
        if (reset || !level) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (rpt_fire) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
        end else begin
            rpt_cnt <= rpt_cnt + REPEAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pulse <= 1'b0;
        end else begin
            pulse <= press || rpt_fire;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            pulse <= 1'b0;
        end else begin
            pulse <= press;
        end
    end
`endif

endmodule

// File: rtl/control_input_frontend.sv
// Button conditioning and pseudo-random source feeding the game FSM.
// Auto-repeat on down/left/right is enabled by defining BTN_AUTOREPEAT_EN.
module control_input_frontend
    import control_input_frontend_pkg::*;
#(
    parameter logic [DEBOUNCE_W-1:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE,
    parameter logic [LFSR_W-1:0]     LFSR_SEED       = DEF_SEED
`ifdef BTN_AUTOREPEAT_EN
    , parameter logic [REPEAT_W-1:0] REPEAT_DELAY  = DEF_REPEAT_DELAY
    , parameter logic [REPEAT_W-1:0] REPEAT_PERIOD = DEF_REPEAT_PERIOD
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              down_btn,
    input  logic              right_btn,
    input  logic              left_btn,
    input  logic              rotate_btn,
    output logic              down_signal,
    output logic              right_signal,
    output logic              left_signal,
    output logic              rotate_signal,
    output logic [LFSR_W-1:0] random,
    output logic [2:0]        random_piece,
    output logic [1:0]        random_rotate
);

    localparam logic [LFSR_W-1:0] SEED_EFF =
        (LFSR_SEED == {LFSR_W{1'b0}}) ? LFSR_SEED_FALLBACK : LFSR_SEED;

    logic [3:0]        btns;
    logic [3:0]        pulses;
    logic [LFSR_W-1:0] lfsr;

    assign btns = {rotate_btn, left_btn, right_btn, down_btn};

    // Channel 3 is rotate, which never auto-repeats
    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
            , .REPEAT_DELAY (REPEAT_DELAY)
            , .REPEAT_PERIOD(REPEAT_PERIOD)
            , .REPEAT_ALLOW (i != 3)
`endif
        ) u_btn (
            .clk  (clk),
            .reset(reset),
            .btn  (btns[i]),
            .pulse(pulses[i])
        );
    end

    assign down_signal   = pulses[0];
    assign right_signal  = pulses[1];
    assign left_signal   = pulses[2];
    assign rotate_signal = pulses[3];

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= SEED_EFF;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign random        = lfsr;
    assign random_piece  = (lfsr[2:0] == 3'b000) ? PIECE_FALLBACK : lfsr[2:0];
    assign random_rotate = lfsr[7:6];

endmodule

// File: tb/tb_control_input_frontend.sv
// Self-checking bench for control_input_frontend (DEBOUNCE_CYCLES=4).
// Auto-repeat checks are included when BTN_AUTOREPEAT_EN is defined.
module tb_control_input_frontend;

    localparam int DEB = 4;
`ifdef BTN_AUTOREPEAT_EN
    localparam int DLY = 8;
    localparam int PER = 3;
    localparam int BOUNCE_EXP = 2;
`else
    localparam int BOUNCE_EXP = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       down_btn = 1'b0, right_btn = 1'b0, left_btn = 1'b0, rotate_btn = 1'b0;
    logic       down_signal, right_signal, left_signal, rotate_signal;
    logic [7:0] random;
    logic [2:0] random_piece;
    logic [1:0] random_rotate;

    control_input_frontend #(
        .DEBOUNCE_CYCLES(20'd4),
        .LFSR_SEED      (8'h01)
`ifdef BTN_AUTOREPEAT_EN
        , .REPEAT_DELAY (24'd8)
        , .REPEAT_PERIOD(24'd3)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .down_btn     (down_btn),
        .right_btn    (right_btn),
        .left_btn     (left_btn),
        .rotate_btn   (rotate_btn),
        .down_signal  (down_signal),
        .right_signal (right_signal),
        .left_signal  (left_signal),
        .rotate_signal(rotate_signal),
        .random       (random),
        .random_piece (random_piece),
        .random_rotate(random_rotate)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: delayed samples, per-channel run length of disagreement
    logic [3:0] m_s1, m_s2, m_lvl, m_pulse;
    int         m_run[4];
`ifdef BTN_AUTOREPEAT_EN
    int         m_age[4];
`endif
    logic [7:0] m_rnd;
    logic [3:0] act_pulse;
    int         pcnt[4];
    int         pfirst[4];

    function automatic logic [7:0] ref_next(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    function automatic logic [2:0] ref_piece(input logic [7:0] x);
        return (x[2:0] == 3'd0) ? 3'd1 : x[2:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [3:0] b, input logic r);
        logic [3:0] prev;
        if (r) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pulse = '0; m_rnd = 8'h01;
            for (int i = 0; i < 4; i++) begin
                m_run[i] = 0;
`ifdef BTN_AUTOREPEAT_EN
                m_age[i] = 0;
`endif
            end
        end else begin
            prev    = m_lvl;
            m_pulse = '0;
            for (int i = 0; i < 4; i++) begin
`ifdef BTN_AUTOREPEAT_EN
                if (prev[i] && i != 3) begin
                    m_age[i]++;
                    if (m_age[i] == DLY || (m_age[i] > DLY && (m_age[i] - DLY) % PER == 0))
                        m_pulse[i] = 1'b1;
                end
`endif
                if (m_s2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_lvl[i] = m_s2[i];
                        m_run[i] = 0;
                        if (m_lvl[i]) begin
                            m_pulse[i] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                            m_age[i] = 0;
`endif
                        end
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s2  = m_s1;
            m_s1  = b;
            m_rnd = ref_next(m_rnd);
        end
    endtask

    task automatic step(input logic [3:0] b, input logic r);
        {rotate_btn, left_btn, right_btn, down_btn} = b;
        reset = r;
        @(posedge clk);
        model_edge(b, r);
        #1;
        act_pulse = {rotate_signal, left_signal, right_signal, down_signal};
        check("pulses_vs_model", 32'(act_pulse), 32'(m_pulse));
        check("random_vs_model", 32'({random_rotate, random_piece, random}),
              32'({m_rnd[7:6], ref_piece(m_rnd), m_rnd}));
    endtask

    task automatic clear_tally();
        for (int i = 0; i < 4; i++) begin
            pcnt[i]   = 0;
            pfirst[i] = -1;
        end
    endtask

    task automatic tally(input int e);
        for (int i = 0; i < 4; i++) begin
            if (act_pulse[i]) begin
                pcnt[i]++;
                if (pfirst[i] < 0) pfirst[i] = e;
            end
        end
    endtask

    typedef struct {
        logic [7:0] rnd;
        logic [2:0] piece;
        logic [1:0] rot;
    } lfsr_vec_t;

    typedef struct {
        logic [3:0] mask;
        int         hold;
        int         exp_cnt;
        int         exp_edge;
    } press_vec_t;

    lfsr_vec_t  lt[8];
    press_vec_t pv[7];
`ifdef BTN_AUTOREPEAT_EN
    int         rpt_exp[9];
    int         rpt_seen[$];
`endif

    initial begin
        lt[0] = '{8'h01, 3'd1, 2'd0};
        lt[1] = '{8'h02, 3'd2, 2'd0};
        lt[2] = '{8'h04, 3'd4, 2'd0};
        lt[3] = '{8'h08, 3'd1, 2'd0};
        lt[4] = '{8'h11, 3'd1, 2'd0};
        lt[5] = '{8'h23, 3'd3, 2'd0};
        lt[6] = '{8'h47, 3'd7, 2'd1};
        lt[7] = '{8'h8E, 3'd6, 2'd2};

        pv[0] = '{4'b0001, 6, 1, DEB + 1};
        pv[1] = '{4'b0010, 6, 1, DEB + 1};
        pv[2] = '{4'b0100, 6, 1, DEB + 1};
        pv[3] = '{4'b1000, 6, 1, DEB + 1};
        pv[4] = '{4'b1111, 6, 1, DEB + 1};
        pv[5] = '{4'b1010, 6, 1, DEB + 1};
        pv[6] = '{4'b0101, 3, 0, -1};

        // Reset and LFSR sequence
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        check("reset_random", 32'(random), 32'h01);
        check("reset_pulses", 32'(act_pulse), 32'h0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step(4'b0000, 1'b0);
            check($sformatf("lfsr_tbl%0d_random", i), 32'(random), 32'(lt[i].rnd));
            check($sformatf("lfsr_tbl%0d_piece", i), 32'(random_piece), 32'(lt[i].piece));
            check($sformatf("lfsr_tbl%0d_rotate", i), 32'(random_rotate), 32'(lt[i].rot));
        end
        for (int i = 8; i < 256; i++) begin
            step(4'b0000, 1'b0);
            check("lfsr_nonzero", 32'(random != 8'h00), 32'h1);
            if (i == 255) check("lfsr_period", 32'(random), 32'h01);
        end

        // Table of presses: one clean pulse per channel DEB+1 edges after capture
        for (int t = 0; t < 7; t++) begin
            clear_tally();
            for (int e = 0; e < 20; e++) begin
                step((e < pv[t].hold) ? pv[t].mask : 4'b0000, 1'b0);
                tally(e);
            end
            for (int c = 0; c < 4; c++) begin
                check($sformatf("press%0d_ch%0d_count", t, c), 32'(pcnt[c]),
                      pv[t].mask[c] ? 32'(pv[t].exp_cnt) : 32'h0);
                if (pv[t].mask[c] && pv[t].exp_cnt > 0)
                    check($sformatf("press%0d_ch%0d_edge", t, c), 32'(pfirst[c]),
                          32'(pv[t].exp_edge));
            end
        end

        // Bouncing left button never completes the count
        clear_tally();
        for (int r = 0; r < 6; r++) begin
            for (int e = 0; e < 4; e++) begin
                step((e < 3) ? 4'b0100 : 4'b0000, 1'b0);
                tally(e);
            end
        end
        check("bounce_no_pulse", 32'(pcnt[2]), 32'h0);
        clear_tally();
        for (int e = 0; e < 25; e++) begin
            step((e < 10) ? 4'b0100 : 4'b0000, 1'b0);
            tally(e);
        end
        check("bounce_then_hold_count", 32'(pcnt[2]), 32'(BOUNCE_EXP));
        check("bounce_then_hold_edge", 32'(pfirst[2]), 32'(DEB + 1));

        // Reset two cycles into the right-button count
        clear_tally();
        for (int e = 0; e < 4; e++) begin
            step(4'b0010, 1'b0);
            tally(e);
        end
        step(4'b0010, 1'b1);
        tally(0);
        check("reset_midcount_no_pulse", 32'(pcnt[1]), 32'h0);
        clear_tally();
        for (int e = 1; e < 12; e++) begin
            step(4'b0010, 1'b0);
            tally(e);
        end
        check("reset_release_count", 32'(pcnt[1]), 32'h1);
        check("reset_release_edge", 32'(pfirst[1]), 32'(DEB + 2));
        for (int e = 0; e < 12; e++) step(4'b0000, 1'b0);

`ifdef BTN_AUTOREPEAT_EN
        // Down repeats at press, +8, then every 3 until the release is accepted
        rpt_exp = '{5, 13, 16, 19, 22, 25, 28, 31, 34};
        rpt_seen.delete();
        clear_tally();
        for (int e = 0; e < 42; e++) begin
            step((e < 30) ? 4'b1001 : 4'b0000, 1'b0);
            tally(e);
            if (down_signal) rpt_seen.push_back(e);
        end
        check("repeat_down_count", 32'(rpt_seen.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < rpt_seen.size())
                check($sformatf("repeat_down_edge%0d", i), 32'(rpt_seen[i]), 32'(rpt_exp[i]));
        end
        check("repeat_rotate_single", 32'(pcnt[3]), 32'h1);
        check("piece_fallback_08", 32'(ref_piece(8'h08)), 32'h1);
`endif

        // Randomized buttons and occasional resets against the model
        begin
            logic [3:0] b;
            b = 4'b0000;
            for (int n = 0; n < 4000; n++) begin
                for (int c = 0; c < 4; c++)
                    if ($urandom_range(5, 0) == 0) b[c] = ~b[c];
                step(b, ($urandom_range(499, 0) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_input_frontend.md
# control_input_frontend

Front-end for the game logic controller: conditions four raw push-button inputs (down, right, left, rotate) into clean single-cycle command pulses, and supplies a free-running 8-bit pseudo-random value plus derived piece and rotation selectors. All outputs are registered or derived directly from registers. The block sits between the board I/O pins and the game FSM.

## Interface
- DEBOUNCE_CYCLES, 20'd250000: consecutive cycles a synchronized button level must differ from the accepted level before it is accepted (minimum 1).
- LFSR_SEED, 8'h01: LFSR reset value. A seed of 0 is replaced by 8'h01.
- REPEAT_DELAY, 24'd12500000: hold time before the first auto-repeat pulse. Used only with the macro.
- REPEAT_PERIOD, 24'd5000000: interval between later auto-repeat pulses. Used only with the macro.
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- down_btn, right_btn, left_btn, rotate_btn  in  1 each  raw, asynchronous, active-high buttons.
- down_signal, right_signal, left_signal, rotate_signal  out  1 each  one-cycle command pulses.
- random  out  8  current LFSR state.
- random_piece  out  3  random[2:0], or 3'b001 when random[2:0] == 0.
- random_rotate  out  2  random[7:6].

## Operation
- Each button channel has the same structure:
  - A 2-flop synchronizer (s1, s2), followed by a counter and an accepted level.
  - When s2 == accepted level, the counter clears to 0.
  - Otherwise the counter increments. On the edge where counter == DEBOUNCE_CYCLES-1 and s2 still differs, the accepted level takes s2 and the counter clears.
  - A bounce, meaning s2 returning to the accepted level before the count completes, restarts the count from 0.
  - The pulse is registered. It goes high on the same edge where the accepted level changes 0->1, for exactly one cycle.
  - A 1->0 transition of the accepted level produces no pulse.
- Channels are fully independent. Simultaneous presses produce simultaneous pulses; no priority is applied here, because the consumer prioritizes.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, period 255.
  - Advances every cycle with no enable: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - The state is never 0.

## Timing
- Reset values: s1, s2, accepted levels, counters and all pulse outputs are 0; the LFSR equals LFSR_SEED (or 8'h01).
- Reset asserted mid-count or mid-hold: everything returns to its reset value on that edge. A button still held after reset release must pass the full debounce again, then pulses once.
- Press latency, when a stable high raw input is first captured by s1 at edge k:
  - The accepted level and the pulse rise at edge k+1+DEBOUNCE_CYCLES.
  - The pulse falls at the next edge.
- Release: the accepted level falls at edge k+1+DEBOUNCE_CYCLES after the low level is first captured. No output changes.
- random_piece and random_rotate are combinational from the LFSR register. They have the same timing as `random`.

## Configuration
- BTN_AUTOREPEAT_EN defined:
  - On down, left and right, while the accepted level stays 1, a further pulse is issued REPEAT_DELAY cycles after the press pulse.
  - After that, a pulse is issued every REPEAT_PERIOD cycles.
  - The repeat counter clears when the accepted level falls or on reset.
  - Rotate never repeats.
- Not defined: exactly one pulse per accepted press on all channels. The repeat counters and repeat parameters are not synthesized.

## Structure
- Shared package holds:
  - LFSR width (8) and the tap mask 8'hB8.
  - The piece-index fallback 3'b001.
  - The default debounce and repeat constants.
- One sub-module, `btn_conditioner`, instantiated four times. It contains the synchronizer, the debounce counter, the edge pulse and the optional repeat logic, with a per-instance REPEAT_ALLOW parameter (0 for rotate).
- The LFSR is inline in the top module.

## Test plan
- Reset, then free run: `random` reads 01, 02, 04, 08, 11, 23, 47 on successive cycles; the sequence returns to 01 after 255 cycles and never shows 00.
- DEBOUNCE_CYCLES=4, down_btn held high: exactly one down_signal pulse, rising at edge k+5 and one cycle wide; no pulse on release.
- DEBOUNCE_CYCLES=4, left_btn toggling high 3 cycles, low 1 cycle, repeated: no pulse; then held high for 10 cycles: exactly one pulse.
- All four buttons rise on the same cycle: all four pulses assert on the same cycle.
- reset asserted while right_btn has been held 2 cycles into its count: no pulse; after release of reset, exactly one pulse DEBOUNCE_CYCLES+2 edges later.
- With BTN_AUTOREPEAT_EN, REPEAT_DELAY=8, REPEAT_PERIOD=3, down held: pulses at press, +8, +11, +14. rotate_btn held the same way gives a single pulse. random_piece is 3'b001 whenever random[2:0] == 0 (e.g. random = 8'h08).
